// File: rtl/gb_bus_pkg.sv
// Shared definitions for the Game Boy bus write-capture front end and the
// cartridge mapper behind it.
//   - cap_state_e : capture FSM encoding
//   - EV_W        : packed event width {cs, addr[3:0], data[7:0]}
//   - NIB_*       : mapper register address nibbles (GB_A[15:12])
//   - pack_event  : builds a packed event word
package gb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    ARMED = 2'd2
  } cap_state_e;

  localparam int EV_W = 13;

  localparam logic [3:0] NIB_RAM_EN_0   = 4'h0;
  localparam logic [3:0] NIB_RAM_EN_1   = 4'h1;
  localparam logic [3:0] NIB_ROM_LO     = 4'h2;
  localparam logic [3:0] NIB_ROM_HI     = 4'h3;
  localparam logic [3:0] NIB_RAM_BANK_0 = 4'h4;
  localparam logic [3:0] NIB_RAM_BANK_1 = 4'h5;

  function automatic logic [EV_W-1:0] pack_event(input logic cs,
                                                  input logic [3:0] addr,
                                                  input logic [7:0] data);
    return {cs, addr, data};
  endfunction

endpackage

// File: rtl/gb_event_fifo.sv
// Show-ahead synchronous FIFO for captured bus events.
//   clk, rst_n : clock, async active-low reset (FIFO empties)
//   push/wdata : write request; ignored when full unless a pop happens too
//   pop        : consume head; ignored when empty
//   rdata      : head entry while non-empty, otherwise last popped value
//   empty/full : occupancy flags
module gb_event_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push & (~full | pop_ok);

  // Once drained, keep presenting the last popped entry rather than stale memory.
  assign rdata = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/gb_bus_write_capture.sv
// Oversamples the asynchronous Game Boy bus, filters WR glitches and turns
// each accepted CPU write into one event queued for the mapper.
//   CLK, GB_RST      : block clock, async active-low reset
//   GB_A/GB_D        : bus address nibble [15:12] and data (async)
//   GB_WR/GB_CS      : active-low write strobe and RAM chip select (async)
//   EV_VALID/READY   : event handshake, pop on VALID & READY
//   EV_ADDR/DATA/CS  : head event fields (EV_CS=1 means GB_CS was low)
//   OVERFLOW         : sticky, an event was dropped on a full FIFO
//   GLITCH           : one-cycle pulse when a short WR-low is discarded
//
// state | meaning
// IDLE  | waiting for a synchronized WR-low
// LOW   | WR low for fewer than FILTER_LEN samples, still a glitch candidate
// ARMED | write accepted, tracking last low sample until WR rises
module gb_bus_write_capture
  import gb_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       GB_RST,
  input  logic [3:0] GB_A,
  input  logic [7:0] GB_D,
  input  logic       GB_WR,
  input  logic       GB_CS,
  output logic       EV_VALID,
  input  logic       EV_READY,
  output logic [3:0] EV_ADDR,
  output logic [7:0] EV_DATA,
  output logic       EV_CS,
  output logic       OVERFLOW,
  output logic       GLITCH
);

  localparam logic [3:0] FLEN = 4'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [3:0]             a_sync [SYNC_STAGES];
  logic [7:0]             d_sync [SYNC_STAGES];
  logic                   wr_s;
  logic                   cs_s;
  logic [3:0]             a_s;
  logic [7:0]             d_s;

  // Strobes reset to their inactive (high) level so reset release looks idle.
  always_ff @(posedge CLK or negedge GB_RST) begin
    if (!GB_RST) begin
      wr_sync <= '1;
      cs_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_sync[i] <= '0;
        d_sync[i] <= '0;
      end
    end else begin
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], GB_WR};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], GB_CS};
      a_sync[0] <= GB_A;
      d_sync[0] <= GB_D;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_sync[i] <= a_sync[i-1];
        d_sync[i] <= d_sync[i-1];
      end
    end
  end

  assign wr_s = wr_sync[SYNC_STAGES-1];
  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign a_s  = a_sync[SYNC_STAGES-1];
  assign d_s  = d_sync[SYNC_STAGES-1];

  cap_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [EV_W-1:0] hold_q, hold_d;
  logic [EV_W-1:0] capture;
  logic            glitch_q, glitch_d;
  logic            ovf_q;
  logic            push;
  logic            fifo_empty;
  logic            fifo_full;
  logic [EV_W-1:0] head;

  assign capture = pack_event(~cs_s, a_s, d_s);

  always_ff @(posedge CLK or negedge GB_RST) begin
    if (!GB_RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      glitch_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      glitch_q <= glitch_d;
      // Drop happens when the FIFO is full and the head is not leaving this cycle.
      if (push && fifo_full && !(EV_READY && !fifo_empty)) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    glitch_d = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!wr_s) begin
          cnt_d   = 4'd1;
          hold_d  = capture;
          state_d = (FLEN == 4'd1) ? ARMED : LOW;
        end
      end
      LOW: begin
        if (!wr_s) begin
          hold_d = capture;
          if (cnt_q < FLEN) cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 >= FLEN) state_d = ARMED;
        end else begin
          glitch_d = 1'b1;
          state_d  = IDLE;
        end
      end
      ARMED: begin
        // Keep recapturing so the committed value is the last low sample.
        if (!wr_s) begin
          hold_d = capture;
        end else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  gb_event_fifo #(
    .WIDTH(EV_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(GB_RST),
    .push (push),
    .wdata(hold_q),
    .pop  (EV_READY),
    .rdata(head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign EV_VALID = ~fifo_empty;
  assign EV_CS    = head[12];
  assign EV_ADDR  = head[11:8];
  assign EV_DATA  = head[7:0];
  assign OVERFLOW = ovf_q;
  assign GLITCH   = glitch_q;

endmodule

// File: tb/tb_gb_bus_write_capture.sv
module tb_gb_bus_write_capture;

  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       GB_RST = 1'b0;
  logic [3:0] GB_A = '0;
  logic [7:0] GB_D = '0;
  logic       GB_WR = 1'b1;
  logic       GB_CS = 1'b1;
  logic       EV_READY = 1'b0;
  logic       EV_VALID;
  logic [3:0] EV_ADDR;
  logic [7:0] EV_DATA;
  logic       EV_CS;
  logic       OVERFLOW;
  logic       GLITCH;

  int vectors = 0;
  int miscompares = 0;
  int glitch_seen = 0;

  gb_bus_write_capture #(
    .SYNC_STAGES(SYNC),
    .FILTER_LEN (FILT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK     (CLK),
    .GB_RST  (GB_RST),
    .GB_A    (GB_A),
    .GB_D    (GB_D),
    .GB_WR   (GB_WR),
    .GB_CS   (GB_CS),
    .EV_VALID(EV_VALID),
    .EV_READY(EV_READY),
    .EV_ADDR (EV_ADDR),
    .EV_DATA (EV_DATA),
    .EV_CS   (EV_CS),
    .OVERFLOW(OVERFLOW),
    .GLITCH  (GLITCH)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (GLITCH === 1'b1) glitch_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    GB_RST = 1'b0; EV_READY = 1'b0; GB_WR = 1'b1; GB_CS = 1'b1; GB_A = '0; GB_D = '0;
    repeat (3) @(negedge CLK);
    GB_RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // WR is held low for exactly 'low' sampling edges; d_last is on the bus for the last one.
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] d_last,
                           input logic cs_n, input int low, input int high);
    @(negedge CLK);
    GB_A = a; GB_D = d; GB_CS = cs_n; GB_WR = 1'b0;
    for (int i = 0; i < low - 1; i++) @(negedge CLK);
    GB_D = d_last;
    @(negedge CLK);
    GB_WR = 1'b1;
    repeat (high) @(negedge CLK);
  endtask

  task automatic test_reset();
    GB_RST = 1'b0; GB_WR = 1'b1; GB_CS = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({EV_VALID, EV_ADDR, EV_DATA, EV_CS, OVERFLOW, GLITCH} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0000", {EV_VALID, EV_ADDR, EV_DATA, EV_CS, OVERFLOW, GLITCH});
    end
    GB_RST = 1'b1;
    repeat (6) @(negedge CLK);
    vectors++;
    if ({EV_VALID, OVERFLOW, GLITCH} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected 000", {EV_VALID, OVERFLOW, GLITCH});
    end
  endtask

  task automatic test_latency();
    bus_write(4'h2, 8'h05, 8'h05, 1'b1, 8, 0);
    for (int e = 0; e < SYNC + 1; e++) begin
      @(negedge CLK);
      vectors++;
      if (EV_VALID !== (e == SYNC)) begin
        miscompares++;
        $display("FAIL latency_valid edge N+%0d: got %b expected %b", e, EV_VALID, (e == SYNC));
      end
    end
    vectors++;
    if ({EV_CS, EV_ADDR, EV_DATA} !== {1'b0, 4'h2, 8'h05}) begin
      miscompares++;
      $display("FAIL latency_event: got %h expected %h", {EV_CS, EV_ADDR, EV_DATA}, {1'b0, 4'h2, 8'h05});
    end
    EV_READY = 1'b1;
    @(negedge CLK);
    EV_READY = 1'b0;
    vectors++;
    if ({EV_VALID, EV_DATA} !== {1'b0, 8'h05}) begin
      miscompares++;
      $display("FAIL pop_then_hold: got valid=%b data=%h expected valid=0 data=05", EV_VALID, EV_DATA);
    end
  endtask

  task automatic test_glitch();
    int g0;
    g0 = glitch_seen;
    bus_write(4'h2, 8'h77, 8'h77, 1'b1, 1, 6);
    vectors++;
    if (glitch_seen !== g0 + 1 || EV_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch: got pulses=%0d valid=%b expected pulses=1 valid=0", glitch_seen - g0, EV_VALID);
    end
    bus_write(4'h3, 8'h78, 8'h78, 1'b1, 4, 5);
    vectors++;
    if ({EV_VALID, EV_CS, EV_ADDR, EV_DATA} !== {1'b1, 1'b0, 4'h3, 8'h78}) begin
      miscompares++;
      $display("FAIL after_glitch_event: got %h expected %h", {EV_VALID, EV_CS, EV_ADDR, EV_DATA}, {1'b1, 1'b0, 4'h3, 8'h78});
    end
    EV_READY = 1'b1; @(negedge CLK); EV_READY = 1'b0;
  endtask

  task automatic drain_expect(input logic [7:0] exp [], input string name);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (EV_VALID !== 1'b1 || EV_DATA !== exp[i]) begin
        miscompares++;
        $display("FAIL %s[%0d]: got valid=%b data=%h expected valid=1 data=%h", name, i, EV_VALID, EV_DATA, exp[i]);
      end
      EV_READY = 1'b1; @(negedge CLK); EV_READY = 1'b0;
    end
    vectors++;
    if (EV_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_empty: got valid=%b expected 0", name, EV_VALID);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [];
    do_reset();
    for (int i = 1; i <= 5; i++) bus_write(4'h2, 8'(i), 8'(i), 1'b1, 4, 3);
    repeat (4) @(negedge CLK);
    vectors++;
    if (OVERFLOW !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flag: got %b expected 1", OVERFLOW);
    end
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    drain_expect(exp, "overflow_drain");
  endtask

  task automatic test_full_pop_commit();
    logic [7:0] exp [];
    do_reset();
    for (int i = 1; i <= 4; i++) bus_write(4'h2, 8'(i), 8'(i), 1'b1, 4, 3);
    repeat (4) @(negedge CLK);
    bus_write(4'h2, 8'h06, 8'h06, 1'b1, 4, 0);
    repeat (SYNC) @(negedge CLK);
    EV_READY = 1'b1;
    @(negedge CLK);
    EV_READY = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (OVERFLOW !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pop_overflow: got %b expected 0", OVERFLOW);
    end
    exp = '{8'h02, 8'h03, 8'h04, 8'h06};
    drain_expect(exp, "full_pop_drain");
  endtask

  task automatic test_cs_data_change();
    bus_write(4'hA, 8'h3C, 8'h3C, 1'b0, 5, 5);
    vectors++;
    if ({EV_VALID, EV_CS, EV_ADDR, EV_DATA} !== {1'b1, 1'b1, 4'hA, 8'h3C}) begin
      miscompares++;
      $display("FAIL cs_event: got %h expected %h", {EV_VALID, EV_CS, EV_ADDR, EV_DATA}, {1'b1, 1'b1, 4'hA, 8'h3C});
    end
    EV_READY = 1'b1; @(negedge CLK); EV_READY = 1'b0;
    bus_write(4'hA, 8'h3C, 8'h3D, 1'b0, 5, 5);
    vectors++;
    if ({EV_VALID, EV_CS, EV_ADDR, EV_DATA} !== {1'b1, 1'b1, 4'hA, 8'h3D}) begin
      miscompares++;
      $display("FAIL last_sample_data: got %h expected %h", {EV_VALID, EV_CS, EV_ADDR, EV_DATA}, {1'b1, 1'b1, 4'hA, 8'h3D});
    end
    EV_READY = 1'b1; @(negedge CLK); EV_READY = 1'b0;
    GB_CS = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_write(4'h2, 8'h11, 8'h11, 1'b1, 4, 3);
    bus_write(4'h2, 8'h22, 8'h22, 1'b1, 4, 3);
    repeat (3) @(negedge CLK);
    GB_A = 4'h5; GB_D = 8'h99; GB_WR = 1'b0;
    repeat (6) @(negedge CLK);
    #2 GB_RST = 1'b0;
    #1;
    vectors++;
    if ({EV_VALID, EV_ADDR, EV_DATA, EV_CS, OVERFLOW, GLITCH} !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %h expected 0000", {EV_VALID, EV_ADDR, EV_DATA, EV_CS, OVERFLOW, GLITCH});
    end
    GB_WR = 1'b1;
    @(negedge CLK);
    GB_RST = 1'b1;
    repeat (8) @(negedge CLK);
    vectors++;
    if (EV_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_spurious: got valid=%b expected 0", EV_VALID);
    end
    bus_write(4'h4, 8'h07, 8'h07, 1'b1, 4, 5);
    vectors++;
    if ({EV_VALID, EV_ADDR, EV_DATA} !== {1'b1, 4'h4, 8'h07}) begin
      miscompares++;
      $display("FAIL reset_mid_next: got %h expected %h", {EV_VALID, EV_ADDR, EV_DATA}, {1'b1, 4'h4, 8'h07});
    end
    EV_READY = 1'b1; @(negedge CLK); EV_READY = 1'b0;
    vectors++;
    if (EV_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_single: got valid=%b expected 0", EV_VALID);
    end
  endtask

  // Reference: a write of L low samples is an event iff L >= FILTER_LEN, carrying
  // the bus value of its last low sample; events queue up to DEPTH, extras are lost.
  task automatic test_random();
    logic [12:0] q [$];
    logic        exp_ovf;
    int          exp_g;
    int          g0;
    logic [3:0]  a;
    logic [7:0]  d, dl;
    logic        cs_n;
    int          len, gap, k;
    exp_ovf = 1'b0;
    for (int r = 0; r < 24; r++) begin
      if (r % 6 == 0) begin
        do_reset();
        exp_ovf = 1'b0;
      end
      g0 = glitch_seen;
      exp_g = 0;
      k = $urandom_range(1, 6);
      for (int w = 0; w < k; w++) begin
        a    = 4'($urandom);
        d    = 8'($urandom);
        dl   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : d;
        cs_n = 1'($urandom_range(0, 1));
        len  = $urandom_range(1, 6);
        gap  = $urandom_range(1, 3);
        bus_write(a, d, dl, cs_n, len, gap);
        if (len >= FILT) begin
          if (q.size() < DEPTH) q.push_back({~cs_n, a, dl});
          else exp_ovf = 1'b1;
        end else begin
          exp_g++;
        end
      end
      repeat (5) @(negedge CLK);
      vectors++;
      if (glitch_seen - g0 !== exp_g || OVERFLOW !== exp_ovf) begin
        miscompares++;
        $display("FAIL rand_flags round %0d: got glitches=%0d ovf=%b expected glitches=%0d ovf=%b",
                 r, glitch_seen - g0, OVERFLOW, exp_g, exp_ovf);
      end
      for (int c = 0; c < 200; c++) begin
        vectors++;
        if (EV_VALID !== (q.size() != 0)) begin
          miscompares++;
          $display("FAIL rand_valid round %0d: got %b expected %b", r, EV_VALID, (q.size() != 0));
        end else if (q.size() != 0 && {EV_CS, EV_ADDR, EV_DATA} !== q[0]) begin
          miscompares++;
          $display("FAIL rand_event round %0d: got %h expected %h", r, {EV_CS, EV_ADDR, EV_DATA}, q[0]);
        end
        if (q.size() == 0) break;
        EV_READY = 1'($urandom_range(0, 1));
        if (EV_READY) void'(q.pop_front());
        @(negedge CLK);
      end
      EV_READY = 1'b0;
      if (q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rand_drain_timeout round %0d: got %0d left expected 0", r, q.size());
        q.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_cs_data_change();
    test_overflow();
    test_full_pop_commit();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
